mac_dot_seq: RTL

//  Upstream sequencer and result-capture stage for the mac unit: one dot product per transaction.
//  - Accepts a stream of (a,b) operand pairs through a valid/ready handshake.
//  - Issues the pairs to the mac, with acc_clear aligned to the first term.
//  - Waits out the mac pipeline, captures the accumulated sum and presents it on a valid/ready result port.
//  - Sits between the matrix operand fetch logic and one mac instance.

---
 rtl/mac_dot_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for one mac: issues (a,b) pairs with acc_clear on the first term,
// waits out the mac pipeline, then holds the captured sum on a valid/ready result port.
module mac_dot_seq #(
  parameter  int DATA_W  = 16,
  parameter  int K_MAX   = 4,
  parameter  int MAC_LAT = 2,
  localparam int ACC_W   = 2*DATA_W + $clog2(K_MAX) + 1,
  localparam int TW      = $clog2(K_MAX+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clear,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [TW-1:0]     res_terms,
  output logic              err_len,
  output logic [1:0]        dbg_state
);

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready
  // are both high; valid never depends on ready, and in_ready depends only on state.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;

  localparam int            DW         = $clog2(MAC_LAT+2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT+1);
  localparam logic [TW-1:0] K_LAST     = TW'(K_MAX);

  state_t              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [DATA_W-1:0]   mac_a_q, mac_a_d;
  logic [DATA_W-1:0]   mac_b_q, mac_b_d;
  logic                mac_clear_q, mac_clear_d;
  logic                err_len_q, err_len_d;
  logic                res_valid_q, res_valid_d;
  logic [ACC_W-1:0]    res_data_q, res_data_d;
  logic [TW-1:0]       res_terms_q, res_terms_d;
  logic                accept;
  logic [TW-1:0]       cnt_inc;
  logic                close;

  assign in_ready  = (state_q == IDLE) || (state_q == ISSUE);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = (state_q == IDLE) ? TW'(1) : cnt_q + TW'(1);
  // A sequence closes on in_last or when the term budget is exhausted.
  assign close     = in_last || (cnt_inc == K_LAST);

  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_clear = mac_clear_q;
  assign err_len   = err_len_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_terms = res_terms_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_clear_d = 1'b0;
    err_len_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_terms_d = res_terms_q;
    case (state_q)
      IDLE, ISSUE: begin
        if (accept) begin
          mac_a_d     = in_a;
          mac_b_d     = in_b;
          mac_clear_d = (state_q == IDLE);
          cnt_d       = cnt_inc;
          if (close) begin
            state_d   = DRAIN;
            drain_d   = '0;
            err_len_d = !in_last;
          end else begin
            state_d   = ISSUE;
          end
        end
      end
      DRAIN: begin
        // mac_acc is final one cycle before this capture edge.
        if (drain_q == DRAIN_LAST) begin
          res_data_d  = mac_acc;
          res_terms_d = cnt_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_clear_q <= 1'b0;
      err_len_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_terms_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_clear_q <= mac_clear_d;
      err_len_q   <= err_len_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_terms_q <= res_terms_d;
    end
  end

endmodule
